// File: rtl/line_mem_responder_if.sv
// Cache-to-memory line bus between a cache miss engine (master) and a line memory (slave).
// Handshake: the master raises mem_read or mem_write with mem_addr/mem_wdata and holds them
// until it sees the one-cycle mem_ready pulse; mem_rdata is meaningful only while mem_ready=1.
interface line_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 128-bit line memory answering one cache line request at a time.
// Optional MEM_STATS_EN adds saturating read/write completion counters rd_cnt/wr_cnt.
module line_mem_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    line_mem_responder_if.slave       bus,
    output logic                      proto_err,
    output logic [1:0]                dbg_state
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]               rd_cnt,
    output logic [15:0]               wr_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t           state;
    logic [7:0]       cnt;
    logic             op_wr;
    logic [IDX_W-1:0] idx;
    logic [127:0]     wdata_q;
    logic             ready_q;
    logic [127:0]     rdata_q;
    logic             req;
    logic             enter_resp;
    logic             commit;
    logic             unused_addr;

    // Line storage is deliberately left out of reset so contents survive a reset pulse.
    logic [127:0] mem_array [2**IDX_W];

    assign req         = bus.mem_read | bus.mem_write;
    assign enter_resp  = (state == WAIT) && (cnt == 8'd0);
    assign commit      = enter_resp && op_wr;
    assign unused_addr = ^bus.mem_addr[27:IDX_W];

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign dbg_state     = state;

    // A write lands only on the edge entering RESP, so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_array[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    if (req) begin
                        // Read and write together resolve to a write and flag the initiator bug.
                        op_wr   <= bus.mem_write;
                        idx     <= bus.mem_addr[IDX_W-1:0];
                        wdata_q <= bus.mem_wdata;
                        cnt     <= CNT_LOAD;
                        state   <= WAIT;
                        if (bus.mem_read && bus.mem_write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Counting down to zero puts mem_ready exactly LATENCY edges after sampling.
                    if (cnt == 8'd0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= op_wr ? 128'd0 : mem_array[idx];
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (enter_resp) begin
            if (op_wr) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench driving a LATENCY=4 and a LATENCY=1 responder with identical request streams,
// checked by per-instance scoreboards against a line-array model.
module tb_line_mem_responder;

  logic clk;
  logic rst_n;

  line_mem_responder_if if4 ();
  line_mem_responder_if if1 ();

  logic       perr4, perr1;
  logic [1:0] st4, st1;
`ifdef MEM_STATS_EN
  logic [15:0] rdc4, wrc4, rdc1, wrc1;
`endif

  line_mem_responder #(.LATENCY(4), .IDX_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .proto_err(perr4), .dbg_state(st4)
`ifdef MEM_STATS_EN
    , .rd_cnt(rdc4), .wr_cnt(wrc4)
`endif
  );

  line_mem_responder #(.LATENCY(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .proto_err(perr1), .dbg_state(st1)
`ifdef MEM_STATS_EN
    , .rd_cnt(rdc1), .wr_cnt(wrc1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q4[$];
  logic [127:0] exp_q1[$];
  logic [127:0] model[int];
  logic         exp_perr = 1'b0;
  int           exp_rd = 0;
  int           exp_wr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  logic after4 = 1'b0;
  logic after1 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if4.mem_ready) begin
        if (exp_q4.size() == 0) check("lat4_unexpected_ready", 128'd1, 128'd0);
        else check("lat4_rdata", if4.mem_rdata, exp_q4.pop_front());
        check("lat4_proto_err", {127'd0, perr4}, {127'd0, exp_perr});
        after4 = 1'b1;
      end else if (after4) begin
        check("lat4_rdata_after", if4.mem_rdata, 128'd0);
        after4 = 1'b0;
      end
      if (if1.mem_ready) begin
        if (exp_q1.size() == 0) check("lat1_unexpected_ready", 128'd1, 128'd0);
        else check("lat1_rdata", if1.mem_rdata, exp_q1.pop_front());
        check("lat1_proto_err", {127'd0, perr1}, {127'd0, exp_perr});
        after1 = 1'b1;
      end else if (after1) begin
        check("lat1_rdata_after", if1.mem_rdata, 128'd0);
        after1 = 1'b0;
      end
    end else begin
      after4 = 1'b0;
      after1 = 1'b0;
    end
  end

  task automatic drive_both(input logic rd, input logic wr, input logic [27:0] addr,
                            input logic [127:0] data);
    if4.mem_read = rd;  if4.mem_write = wr;  if4.mem_addr = addr;  if4.mem_wdata = data;
    if1.mem_read = rd;  if1.mem_write = wr;  if1.mem_addr = addr;  if1.mem_wdata = data;
  endtask

  task automatic drop4();
    if4.mem_read = 1'b0; if4.mem_write = 1'b0; if4.mem_addr = '0; if4.mem_wdata = '0;
  endtask

  task automatic drop1();
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_addr = '0; if1.mem_wdata = '0;
  endtask

  // driver: one request to both instances, held until each sees its own mem_ready
  task automatic do_op(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data);
    int          line;
    int          k;
    bit          done4, done1;
    logic [127:0] exp;
    line = int'(addr % 256);
    if (wr) begin
      model[line] = data;
      exp = 128'd0;
      exp_wr++;
    end else begin
      exp = model.exists(line) ? model[line] : 128'd0;
      exp_rd++;
    end
    if (rd && wr) exp_perr = 1'b1;
    exp_q4.push_back(exp);
    exp_q1.push_back(exp);
    @(negedge clk);
    drive_both(rd, wr, addr, data);
    k = 0; done4 = 0; done1 = 0;
    while (!(done4 && done1) && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (!done4 && if4.mem_ready) begin
        check("lat4_ready_edges", 128'(k), 128'd5);
        done4 = 1; drop4();
      end
      if (!done1 && if1.mem_ready) begin
        check("lat1_ready_edges", 128'(k), 128'd2);
        done1 = 1; drop1();
      end
    end
    if (!(done4 && done1)) begin
      check("ready_timeout", 128'd0, 128'd1);
      drop4(); drop1();
      exp_q4.delete(); exp_q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // a write abandoned by a reset pulse one cycle after it was sampled
  task automatic do_abort(input logic [27:0] addr, input logic [127:0] data);
    @(negedge clk);
    drive_both(1'b0, 1'b1, addr, data);
    @(negedge clk);
    rst_n = 1'b0;
    drop4(); drop1();
    @(negedge clk);
    check("abort_perr_cleared", {127'd0, perr4}, 128'd0);
    rst_n = 1'b1;
    exp_perr = 1'b0; exp_rd = 0; exp_wr = 0;
    repeat (8) @(negedge clk);
    check("abort_state4_idle", 128'(st4), 128'd0);
    check("abort_state1_idle", 128'(st1), 128'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef MEM_STATS_EN
    check({tag, "_rd_cnt4"}, 128'(rdc4), 128'(exp_rd));
    check({tag, "_wr_cnt4"}, 128'(wrc4), 128'(exp_wr));
    check({tag, "_rd_cnt1"}, 128'(rdc1), 128'(exp_rd));
    check({tag, "_wr_cnt1"}, 128'(wrc1), 128'(exp_wr));
`else
    check({tag, "_perr1"}, {127'd0, perr1}, {127'd0, exp_perr});
`endif
  endtask

  initial begin
    logic [27:0]  addr;
    logic [127:0] data;
    int           line;
    int           choice;
    rst_n = 1'b0;
    drive_both(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready4", {127'd0, if4.mem_ready}, 128'd0);
    check("reset_rdata4", if4.mem_rdata, 128'd0);
    check("reset_perr4", {127'd0, perr4}, 128'd0);
    check("reset_state4", 128'(st4), 128'd0);
    check("reset_ready1", {127'd0, if1.mem_ready}, 128'd0);
    check("reset_perr1", {127'd0, perr1}, 128'd0);
    check_stats("reset");

    do_op(1'b0, 1'b1, 28'h0000010, 128'hDEAD_0000_0000_0000_0000_0000_0000_0001);
    do_op(1'b1, 1'b0, 28'h0000010, 128'd0);
    do_op(1'b0, 1'b1, 28'h0000105, 128'h5);
    do_op(1'b1, 1'b0, 28'h0000005, 128'd0);
    do_op(1'b1, 1'b1, 28'h0000007, 128'hA);
    check("perr_sticky4", {127'd0, perr4}, 128'd1);
    do_op(1'b1, 1'b0, 28'h0000007, 128'd0);
    check("perr_sticky_after_read", {127'd0, perr4}, 128'd1);
    do_op(1'b0, 1'b1, 28'h0000009, 128'hB);
    check_stats("directed");
    do_abort(28'h0000009, 128'hC);
    check_stats("after_abort");
    do_op(1'b1, 1'b0, 28'h0000009, 128'd0);

    for (int n = 0; n < 40; n++) begin
      line = $urandom_range(0, 15);
      addr = 28'($urandom);
      addr[7:0] = 8'(line);
      data = {$urandom, $urandom, $urandom, $urandom};
      choice = $urandom_range(0, 19);
      if (!model.exists(line) || choice < 8) do_op(1'b0, 1'b1, addr, data);
      else if (choice == 19) do_op(1'b1, 1'b1, addr, data);
      else do_op(1'b1, 1'b0, addr, 128'd0);
    end
    check_stats("random");
    check("final_q4_empty", 128'(exp_q4.size()), 128'd0);
    check("final_q1_empty", 128'(exp_q1.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
